result_trace_fifo: RTL
======================

// Module: result_trace_fifo
// PURPOSE
//  Downstream stage of the CPU datapath. Captures every register write-back
//  event {pc, wa, y} into a FIFO and drains it to a consumer (monitor, UART,
//  scoreboard) over a valid/ready handshake. Flags when the program has
//  finished and all results have been drained.
// PARAMETERS
//  DEPTH    8    FIFO entries; power of 2, >= 2
//  AW       3    pointer width = log2(DEPTH)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  we         in   1   write-back enable from control unit (capture strobe)
//  pc         in   8   program counter of the executing instruction
//  wa         in   2   destination register address
//  y          in   8   ALU result being written
//  done       in   1   program-finished flag from control unit
//  out_valid  out  1   head entry available
//  out_ready  in   1   consumer accepts head entry
//  out_data   out  18  head entry {pc[7:0], wa[1:0], y[7:0]}
//  count      out  AW+1 entries currently stored (0..DEPTH)
//  full       out  1   count == DEPTH
//  empty      out  1   count == 0
//  drop_cnt   out  8   events lost to overflow, saturates at 255
//  drained    out  1   done has been seen and FIFO is empty
// BEHAVIOUR
//  Reset (async, immediate): wr_ptr=rd_ptr=0, count=0, drop_cnt=0,
//   done_seen=0; hence out_valid=0, empty=1, full=0, drained=0.
//   out_data = mem[rd_ptr]; memory contents are not reset (don't-care).
//  Push: at a rising edge with we=1, {pc,wa,y} is written to mem[wr_ptr],
//   wr_ptr++ (wraps modulo DEPTH). Visible on out_data the next cycle when
//   the FIFO was empty: capture-to-out_valid latency = 1 clock.
//  Pop: at a rising edge with out_valid && out_ready, rd_ptr++ (wraps).
//   out_data is show-ahead: head presented while out_valid=1 and held
//   stable until popped. out_ready with out_valid=0 has no effect.
//  Simultaneous push+pop:
//   - not full, not empty: both happen, count unchanged.
//   - empty: push only (no valid head to pop); count 0->1.
//   - full: pop frees a slot, push is accepted, count stays DEPTH,
//     drop_cnt unchanged.
//  Overflow: push when full with no pop -> entry discarded, pointers and
//   count unchanged, drop_cnt++ unless already 255.
//  count/full/empty derived from registered state; no combinational path
//   from we or out_ready to out_valid/full/empty.
//  done_seen: set at first edge with done=1, sticky until reset.
//   drained = done_seen && empty (registered state only). A push after
//   done (not expected) clears drained until the entry is popped.
//  Reset mid-operation: all stored entries lost, outputs to reset values
//   asynchronously; no pop reported for discarded entries.
// TESTING
//  1. Reset, we=1 pc=0x00 wa=2 y=0x2A, out_ready=0 -> next cycle
//     out_valid=1, out_data=0x0022A, count=1, empty=0.
//  2. Push 8 events y=1..8, out_ready=0 -> full=1, count=8; 9th push y=9
//     -> drop_cnt=1, count=8; drain -> y order 1..8, y=9 never appears.
//  3. FIFO full, we=1 and out_ready=1 same edge -> count stays 8,
//     drop_cnt unchanged, new entry emerges last.
//  4. Continuous push+pop for 20 cycles (y=0..19) with out_ready=1 ->
//     output sequence 0..19 one cycle behind, count toggles 0/1 only,
//     pointers wrap twice without loss.
//  5. Force 300 drops -> drop_cnt=255, holds; reset -> drop_cnt=0.
//  6. 3 entries queued, pulse done, drain -> drained=0 until last pop,
//     then 1; assert reset mid-drain -> out_valid=0, drained=0 instantly.

Source files
------------

// File: rtl/result_trace_fifo_if.sv
// Write-back trace bus: capture side (we/pc/wa/y/done) and drain side
// (valid/ready/data) plus FIFO status.
interface result_trace_fifo_if #(
    parameter int AW = 3
);
    logic          we;
    logic [7:0]    pc;
    logic [1:0]    wa;
    logic [7:0]    y;
    logic          done;
    logic          out_valid;
    logic          out_ready;
    logic [17:0]   out_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic [7:0]    drop_cnt;
    logic          drained;

    // Producer/consumer environment view.
    modport master (
        output we, pc, wa, y, done, out_ready,
        input  out_valid, out_data, count, full, empty, drop_cnt, drained
    );

    // FIFO view.
    modport slave (
        input  we, pc, wa, y, done, out_ready,
        output out_valid, out_data, count, full, empty, drop_cnt, drained
    );
endinterface

// File: rtl/result_trace_fifo.sv
// Captures register write-back events {pc, wa, y} into a show-ahead FIFO and
// drains them over valid/ready. Overflowing events are counted (saturating),
// and drained flags that the program finished and every result was consumed.
module result_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                clk,
    input  logic                reset,
    result_trace_fifo_if.slave  bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [7:0]    drop_q;
    logic          done_seen;

    logic          empty_w;
    logic          full_w;
    logic          pop;
    logic          push;
    logic          drop;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_CNT);

    // A pop only happens when a head is actually presented; when full, a
    // simultaneous pop frees the slot the incoming push lands in.
    assign pop  = !empty_w && bus.out_ready;
    assign push = bus.we && (!full_w || pop);
    assign drop = bus.we && full_w && !pop;

    // Pointer, occupancy, overflow and done bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            done_seen <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (drop && (drop_q != 8'hFF))
                drop_q <= drop_q + 8'd1;
            if (bus.done)
                done_seen <= 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.pc, bus.wa, bus.y};
    end

    assign bus.out_valid = !empty_w;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.count     = count_q;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.drop_cnt  = drop_q;
    assign bus.drained   = done_seen && empty_w;
endmodule
